// File: rtl/traffic_request_conditioner_if.sv
// traffic_request_conditioner_if
//   Bundles the traffic request conditioner's detector, colour-feedback and
//   request signals.
//   slave  : used by the conditioner. Raw inputs and colour buses come in.
//            SA/SB/PED_WAIT_A/PED_WAIT_B go out.
//   master : used by the driving side, such as the detectors/controller
//            model or a testbench.
//   Signals:
//     CAR_A, CAR_B  raw car detectors (async, may bounce)
//     PED_A, PED_B  raw pedestrian buttons
//     A, B [1:0]    controller colour per road: 00 RED, 01 YELLOW, 10 GREEN, 11 BLINKING_RED
//     SA, SB        latched green requests to the controller
//     PED_WAIT_A/B  pedestrian wait lamps
interface traffic_request_conditioner_if;
  logic       CAR_A;
  logic       CAR_B;
  logic       PED_A;
  logic       PED_B;
  logic [1:0] A;
  logic [1:0] B;
  logic       SA;
  logic       SB;
  logic       PED_WAIT_A;
  logic       PED_WAIT_B;

  modport master (
    output CAR_A, CAR_B, PED_A, PED_B, A, B,
    input  SA, SB, PED_WAIT_A, PED_WAIT_B
  );

  modport slave (
    input  CAR_A, CAR_B, PED_A, PED_B, A, B,
    output SA, SB, PED_WAIT_A, PED_WAIT_B
  );
endinterface

// File: rtl/traffic_request_conditioner.sv
// traffic_request_conditioner
//   Upstream stage of the traffic light controller. Each raw car detector and
//   pedestrian button is synchronised (2 flops) and debounced. The module then
//   produces latched green requests SA/SB and pedestrian wait lamps.
//   A request clears when the controller shows GREEN on the corresponding
//   colour bus.
//   Cars are level-sensitive. Pedestrian buttons act only on the rising edge
//   of the debounced level.
//   Parameters:
//     DEB_CYCLES (1..15) stable cycles needed to accept a new debounced level
//     MAX_WAIT   (1..255) continuous-green cycles before the opposite request
//                is forced (AUTO_REQ_EN only)
//   Optional feature: define AUTO_REQ_EN to enable starvation protection.
//   Ports:
//     CLK    system clock, posedge
//     RST_N  asynchronous active-low reset
//     bus    traffic_request_conditioner_if.slave (detectors, colours, requests)
module traffic_request_conditioner #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned MAX_WAIT   = 64
) (
  input logic                          CLK,
  input logic                          RST_N,
  traffic_request_conditioner_if.slave bus
);

  typedef enum logic [1:0] {
    RED       = 2'b00,
    YELLOW    = 2'b01,
    GREEN     = 2'b10,
    BLINK_RED = 2'b11
  } colour_e;

  // Debounce channel indices
  localparam int unsigned CH_CAR_A = 0;
  localparam int unsigned CH_CAR_B = 1;
  localparam int unsigned CH_PED_A = 2;
  localparam int unsigned CH_PED_B = 3;

  localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 1 || DEB_CYCLES > 15) begin : g_bad_deb
    $error("DEB_CYCLES out of range 1..15");
  end
  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_wait
    $error("MAX_WAIT out of range 1..255");
  end

  colour_e    w_col_a;
  colour_e    w_col_b;
  logic       w_green_a;
  logic       w_green_b;
  logic [3:0] w_raw;
  logic [3:0] r_s1;
  logic [3:0] r_s2;
  logic [3:0] r_deb;
  logic [3:0] r_deb_q;
  logic [3:0] r_cnt [4];
  logic       w_rise_ped_a;
  logic       w_rise_ped_b;
  logic       w_set_a;
  logic       w_set_b;
  logic       w_sa_next;
  logic       w_sb_next;
  logic       w_pw_a_next;
  logic       w_pw_b_next;
  logic       r_sa;
  logic       r_sb;
  logic       r_pw_a;
  logic       r_pw_b;

  assign w_col_a   = colour_e'(bus.A);
  assign w_col_b   = colour_e'(bus.B);
  assign w_green_a = (w_col_a == GREEN);
  assign w_green_b = (w_col_b == GREEN);
  assign w_raw     = {bus.PED_B, bus.PED_A, bus.CAR_B, bus.CAR_A};

  // Synchroniser plus a one-cycle delayed debounced level for edge detection
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_deb_q <= '0;
    end else begin
      r_s1    <= w_raw;
      r_s2    <= r_s1;
      r_deb_q <= r_deb;
    end
  end

  // Debounce: accept s2 after it differs from deb for DEB_CYCLES edges in a row
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_deb <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEB_LAST) begin
          r_deb[i] <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 4'd1;
        end
      end
    end
  end

  // Rise is seen one cycle after deb changes, which puts requests one edge after deb
  assign w_rise_ped_a = r_deb[CH_PED_A] & ~r_deb_q[CH_PED_A];
  assign w_rise_ped_b = r_deb[CH_PED_B] & ~r_deb_q[CH_PED_B];

`ifdef AUTO_REQ_EN
  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  logic [7:0] r_wait_cnt;
  logic       r_wait_on_b;
  logic [7:0] w_wait_next;
  logic       w_force_a;
  logic       w_force_b;

  // Count continuous green of one road. A direct swap of green between roads restarts the count.
  always_comb begin
    w_wait_next = '0;
    if (w_green_a ^ w_green_b) begin
      if (r_wait_cnt != '0 && r_wait_on_b == w_green_b) begin
        w_wait_next = (r_wait_cnt == WAIT_MAX) ? WAIT_MAX : r_wait_cnt + 8'd1;
      end else begin
        w_wait_next = 8'd1;
      end
    end
  end

  assign w_force_b = w_green_a & ~w_green_b & (w_wait_next == WAIT_MAX);
  assign w_force_a = w_green_b & ~w_green_a & (w_wait_next == WAIT_MAX);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wait_cnt  <= '0;
      r_wait_on_b <= 1'b0;
    end else begin
      r_wait_cnt  <= w_wait_next;
      r_wait_on_b <= w_green_b;
    end
  end
`endif

  always_comb begin
    w_set_a = r_deb[CH_CAR_A] | w_rise_ped_a;
    w_set_b = r_deb[CH_CAR_B] | w_rise_ped_b;
`ifdef AUTO_REQ_EN
    w_set_a = w_set_a | w_force_a;
    w_set_b = w_set_b | w_force_b;
`endif
    // Clear wins over set
    w_sa_next   = w_green_a ? 1'b0 : (r_sa | w_set_a);
    w_sb_next   = w_green_b ? 1'b0 : (r_sb | w_set_b);
    // Crossing A needs B green and crossing B needs A green
    w_pw_a_next = w_green_b ? 1'b0 : (r_pw_a | w_rise_ped_a);
    w_pw_b_next = w_green_a ? 1'b0 : (r_pw_b | w_rise_ped_b);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_pw_a <= 1'b0;
      r_pw_b <= 1'b0;
    end else begin
      r_sa   <= w_sa_next;
      r_sb   <= w_sb_next;
      r_pw_a <= w_pw_a_next;
      r_pw_b <= w_pw_b_next;
    end
  end

  assign bus.SA         = r_sa;
  assign bus.SB         = r_sb;
  assign bus.PED_WAIT_A = r_pw_a;
  assign bus.PED_WAIT_B = r_pw_b;

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// tb_traffic_request_conditioner
//   Directed test of traffic_request_conditioner with DEB_CYCLES=4 and MAX_WAIT=64.
//   Inputs change 1 time unit after a rising edge, so the next rising edge
//   is the first edge to sample them.
module tb_traffic_request_conditioner;

  localparam logic [1:0] C_RED    = 2'b00;
  localparam logic [1:0] C_YELLOW = 2'b01;
  localparam logic [1:0] C_GREEN  = 2'b10;
  localparam logic [1:0] C_BLINK  = 2'b11;

  logic CLK;
  logic RST_N;
  int   n_checks;
  int   n_fail;

  traffic_request_conditioner_if bus ();

  traffic_request_conditioner #(
    .DEB_CYCLES (4),
    .MAX_WAIT   (64)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {bus.SA, bus.SB, bus.PED_WAIT_A, bus.PED_WAIT_B};
  endfunction

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    RST_N     = 1'b0;
    bus.CAR_A = 1'b0;
    bus.CAR_B = 1'b0;
    bus.PED_A = 1'b0;
    bus.PED_B = 1'b0;
    bus.A     = C_RED;
    bus.B     = C_RED;

    // Reset state
    #12;
    chk("reset_outs", outs(), 4'b0000);
    RST_N = 1'b1;
    step(2);
    chk("idle_outs", outs(), 4'b0000);

    // T1 latency: SB rises on edge 7, not on edge 6
    bus.A     = C_GREEN;
    bus.CAR_B = 1'b1;
    step(6);
    chk("t1_sb_edge6", bus.SB, 1'b0);
    step(1);
    chk("t1_sb_edge7", bus.SB, 1'b1);
    chk("t1_sa", bus.SA, 1'b0);

    // T3: B green clears SB while the car is held. YELLOW re-sets SB.
    bus.A = C_RED;
    bus.B = C_GREEN;
    step(1);
    chk("t3_sb_clr", bus.SB, 1'b0);
    step(5);
    chk("t3_sb_green_hold", bus.SB, 1'b0);
    bus.B = C_YELLOW;
    step(1);
    chk("t3_sb_reset_yellow", bus.SB, 1'b1);
    // Latched request survives car leaving and BLINKING_RED
    bus.CAR_B = 1'b0;
    bus.B     = C_BLINK;
    step(10);
    chk("t3_sb_blink_hold", bus.SB, 1'b1);
    bus.B = C_GREEN;
    step(1);
    chk("t3_sb_clr2", bus.SB, 1'b0);
    bus.B = C_RED;
    step(1);
    chk("t3_sb_stay_clr", bus.SB, 1'b0);

    // T2 bounce: 3-cycle pulses are discarded
    for (int r = 0; r < 5; r++) begin
      bus.CAR_B = 1'b1;
      step(3);
      bus.CAR_B = 1'b0;
      step(3);
      chk("t2_bounce_sb", bus.SB, 1'b0);
    end
    step(8);
    chk("t2_bounce_tail", outs(), 4'b0000);

    // T4 pedestrian A: 6-cycle pulse
    bus.PED_A = 1'b1;
    step(6);
    chk("t4_ped_edge6", {bus.SA, bus.PED_WAIT_A}, 2'b00);
    bus.PED_A = 1'b0;
    step(1);
    chk("t4_ped_edge7", {bus.SA, bus.PED_WAIT_A}, 2'b11);
    step(10);
    chk("t4_ped_latched", {bus.SA, bus.PED_WAIT_A}, 2'b11);
    bus.B = C_GREEN;
    step(1);
    chk("t4_pw_a_clr_bgreen", {bus.SA, bus.PED_WAIT_A}, 2'b10);
    bus.B = C_RED;
    bus.A = C_GREEN;
    step(1);
    chk("t4_sa_clr_agreen", bus.SA, 1'b0);
    bus.A = C_RED;
    // Held button: one request, then no re-arm
    bus.PED_A = 1'b1;
    step(7);
    chk("t4_held_req", {bus.SA, bus.PED_WAIT_A}, 2'b11);
    bus.A = C_GREEN;
    bus.B = C_GREEN;
    step(1);
    chk("t4_held_clr", {bus.SA, bus.PED_WAIT_A}, 2'b00);
    bus.A = C_RED;
    bus.B = C_RED;
    step(50);
    chk("t4_held_no_rearm", {bus.SA, bus.PED_WAIT_A}, 2'b00);
    bus.PED_A = 1'b0;
    step(10);

    // Pedestrian B: sets SB and PED_WAIT_B. A green clears only the lamp.
    bus.PED_B = 1'b1;
    step(6);
    bus.PED_B = 1'b0;
    chk("pb_edge6", {bus.SB, bus.PED_WAIT_B}, 2'b00);
    step(1);
    chk("pb_edge7", {bus.SB, bus.PED_WAIT_B}, 2'b11);
    bus.A = C_GREEN;
    step(1);
    chk("pb_pw_b_clr", {bus.SB, bus.PED_WAIT_B}, 2'b10);
    bus.A = C_RED;
    bus.B = C_GREEN;
    step(1);
    chk("pb_sb_clr", {bus.SB, bus.PED_WAIT_B}, 2'b00);
    bus.B = C_RED;
    step(10);
    chk("pb_idle", outs(), 4'b0000);

    // T5 reset mid-operation
    bus.CAR_A = 1'b1;
    bus.CAR_B = 1'b1;
    step(7);
    chk("t5_pre", {bus.SA, bus.SB}, 2'b11);
    bus.PED_B = 1'b1;
    step(3);
    #3;
    RST_N = 1'b0;
    #1;
    chk("t5_async_reset", outs(), 4'b0000);
    #2;
    RST_N = 1'b1;
    step(6);
    chk("t5_post_edge6", outs(), 4'b0000);
    step(1);
    chk("t5_post_edge7", outs(), 4'b1101);

    // T6 starvation: A green held with no detections
    bus.CAR_A = 1'b0;
    bus.CAR_B = 1'b0;
    bus.PED_B = 1'b0;
    step(10);
    bus.B = C_GREEN;
    step(1);
    bus.B = C_RED;
    step(1);
    chk("t6_pre", bus.SB, 1'b0);
    bus.A = C_GREEN;
    step(63);
    chk("t6_edge63", outs(), 4'b0000);
    step(1);
`ifdef AUTO_REQ_EN
    chk("t6_edge64_forced", outs(), 4'b0100);
    step(20);
    chk("t6_forced_hold", bus.SB, 1'b1);
`else
    chk("t6_edge64_none", outs(), 4'b0000);
    step(136);
    chk("t6_edge200_none", outs(), 4'b0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
